// File: rtl/nonce_collector_if.sv
// Bundles the core-hit inputs, the queue pop and the queue head outputs of
// nonce_collector. The master side drives hits and pops; the slave side is the collector.
interface nonce_collector_if #(
    parameter int NUM_CORES  = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int ID_W       = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [NUM_CORES-1:0]    match;
    logic [32*NUM_CORES-1:0] nonce_in;
    logic                    pop;
    logic [31:0]             nonce_out;
    logic [ID_W-1:0]         core_out;
    logic                    nonce_valid;
    logic [CNT_W-1:0]        fifo_count;
    logic [7:0]              drop_count;

    modport master (
        output match, nonce_in, pop,
        input  nonce_out, core_out, nonce_valid, fifo_count, drop_count
    );

    modport slave (
        input  match, nonce_in, pop,
        output nonce_out, core_out, nonce_valid, fifo_count, drop_count
    );
endinterface

// File: rtl/nonce_collector.sv
// Golden-nonce collector: per-core holding registers, a round-robin arbiter
// and a small result queue. A hit is lost only when a core hits again while
// its previous hit is still waiting; each such loss bumps a saturating counter.
module nonce_collector #(
    parameter int NUM_CORES  = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int ID_W       = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input logic              clk,
    input logic              reset,
    nonce_collector_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int NDR_W = $clog2(NUM_CORES + 1);

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [31:0]     nonce;
    } entry_t;

    // Holding stage
    logic [NUM_CORES-1:0] pend_q, pend_d;
    logic [31:0]          hold_q [NUM_CORES];
    logic [31:0]          hold_d [NUM_CORES];
    logic [NDR_W-1:0]     n_drop;

    // Arbiter
    logic [ID_W-1:0]      last_grant_q, last_grant_d;
    logic                 grant_valid;
    logic [ID_W-1:0]      grant_idx;

    // Queue
    entry_t               mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    entry_t               head_q, head_d;
    entry_t               push_data;
    logic                 pop_eff;

    logic [7:0]           drop_q, drop_d;
    logic [8:0]           drop_sum;

    // Round-robin pick: first pending core scanning upward from last_grant+1;
    // nothing is granted while the queue is full.
    // NOTE: combinational blocks give every output a default first so no path leaves a latch.
    always_comb begin
        int unsigned cand;
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        if (count_q < CNT_W'(FIFO_DEPTH)) begin
            for (int k = 1; k <= NUM_CORES; k++) begin
                cand = (int'(last_grant_q) + k) % NUM_CORES;
                if (!grant_valid && pend_q[cand]) begin
                    grant_valid = 1'b1;
                    grant_idx   = ID_W'(cand);
                end
            end
        end
        last_grant_d = grant_valid ? grant_idx : last_grant_q;
    end

    // Per-core hold/pending update; a hit arriving while the core is being
    // granted refills the holder instead of being dropped.
    // NOTE: combinational logic uses blocking (=) assignments; the flops below use non-blocking (<=).
    always_comb begin
        pend_d = pend_q;
        hold_d = hold_q;
        n_drop = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (bus.match[i]) begin
                if (!pend_q[i] || (grant_valid && grant_idx == ID_W'(i))) begin
                    hold_d[i] = bus.nonce_in[32*i +: 32];
                    pend_d[i] = 1'b1;
                end else begin
                    n_drop = n_drop + NDR_W'(1);
                end
            end else if (grant_valid && grant_idx == ID_W'(i)) begin
                pend_d[i] = 1'b0;
            end
        end
        drop_sum = 9'(drop_q) + 9'(n_drop);
        drop_d   = (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
    end

    // Queue pointers, occupancy and the registered head. The head register
    // keeps its last value once the queue drains.
    always_comb begin
        push_data.id    = grant_idx;
        push_data.nonce = hold_q[grant_idx];
        pop_eff  = bus.pop && (count_q != '0);
        wr_ptr_d = grant_valid ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop_eff ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q + CNT_W'(grant_valid) - CNT_W'(pop_eff);
        head_d   = head_q;
        if (count_d != '0) begin
            if (grant_valid && (wr_ptr_q == rd_ptr_d)) begin
                head_d = push_data;
            end else begin
                head_d = mem_q[rd_ptr_d];
            end
        end
    end

    // Control state with synchronous reset; queued and pending hits are discarded.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q       <= '0;
            last_grant_q <= ID_W'(NUM_CORES - 1);
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            head_q       <= '0;
            drop_q       <= '0;
        end else begin
            pend_q       <= pend_d;
            last_grant_q <= last_grant_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            head_q       <= head_d;
            drop_q       <= drop_d;
        end
    end

    // Data storage for holders and queue slots.
    // NOTE: storage arrays are not reset; pend/count gate every read so stale contents never surface.
    always_ff @(posedge clk) begin
        hold_q <= hold_d;
        if (grant_valid) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign bus.nonce_out   = head_q.nonce;
    assign bus.core_out    = head_q.id;
    assign bus.nonce_valid = (count_q != '0);
    assign bus.fifo_count  = count_q;
    assign bus.drop_count  = drop_q;
endmodule
